// File: rtl/bp_nonsynth_commit_scoreboard.sv
// bp_nonsynth_commit_scoreboard: pairs in-order commits with out-of-order writebacks for cosim retire.
// BP_NONSYNTH_COMMIT_WATCHDOG_EN enables the stall watchdog driving hang_o; vaddr_width_p stands in for bp_params_p.
module bp_nonsynth_commit_scoreboard #(
    parameter int vaddr_width_p = 39,
    parameter int num_rf_p      = 2,
    parameter int commit_els_p  = 16,
    parameter int wb_els_p      = 4,
    parameter int req_els_p     = 64,
    parameter int timeout_p     = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     commit_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [31:0]              commit_instr_i,
    input  logic                     commit_trap_i,
    input  logic [63:0]              commit_cause_i,
    input  logic                     commit_debug_i,
    input  logic [num_rf_p-1:0]      commit_rf_w_v_i,
    input  logic                     commit_req_v_i,
    input  logic [num_rf_p-1:0]      wb_v_i,
    input  logic [num_rf_p*5-1:0]    wb_addr_i,
    input  logic [num_rf_p*64-1:0]   wb_data_i,
    input  logic                     req_v_i,
    input  logic                     req_complete_i,
    output logic                     retire_v_o,
    input  logic                     retire_yumi_i,
    output logic [63:0]              retire_pc_o,
    output logic [31:0]              retire_instr_o,
    output logic                     retire_trap_o,
    output logic [63:0]              retire_cause_o,
    output logic                     retire_debug_o,
    output logic [num_rf_p-1:0]      retire_rf_sel_o,
    output logic [63:0]              retire_wdata_o,
    output logic [31:0]              retire_cnt_o,
    output logic                     overflow_o,
    output logic                     hang_o
);
    localparam int cp = $clog2(commit_els_p);
    localparam int wp = $clog2(wb_els_p);
    localparam int rw = $clog2(req_els_p + 1);
    localparam int cw = num_rf_p > 1 ? $clog2(num_rf_p) : 1;
    typedef logic [cp:0] cptr_t;
    typedef logic [wp:0] wptr_t;
    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [31:0]              instr;
        logic                     trap;
        logic [63:0]              cause;
        logic                     debug;
        logic [num_rf_p-1:0]      rf_w_v;
        logic                     req_v;
    } rec_t;

    rec_t        cmt_mem_q [commit_els_p];
    cptr_t       cmt_wr_q, cmt_rd_q;
    logic [63:0] wb_mem_q [num_rf_p][32][wb_els_p];
    wptr_t       wb_wr_q [num_rf_p][32];
    wptr_t       wb_rd_q [num_rf_p][32];
    logic [rw-1:0] req_cnt_q, req_cnt_d;
    logic [31:0] retire_cnt_q;
    logic        overflow_q;

    rec_t    head;
    logic [4:0] rd;
    logic [cw-1:0] hc;
    logic [4:0] wa [num_rf_p];
    logic [num_rf_p-1:0][31:0] wb_enq, wb_deq, wb_full, wb_acc;
    logic cmt_empty, cmt_full, cmt_acc, cmt_ovf, uses_wb, wb_ne, ready, fire, deq_wb;
    logic inc, dec, req_ovf;

    assign head      = cmt_mem_q[cmt_rd_q[cp-1:0]];
    assign rd        = head.instr[11:7];
    assign cmt_empty = cmt_wr_q == cmt_rd_q;
    assign cmt_full  = (cmt_wr_q ^ cmt_rd_q) == {1'b1, {cp{1'b0}}};
    assign uses_wb   = |head.rf_w_v & ~(head.rf_w_v[0] & rd == 5'd0);
    assign wb_ne     = wb_wr_q[hc][rd] != wb_rd_q[hc][rd];
    assign ready     = ~cmt_empty & (head.trap | ((~uses_wb | wb_ne) & (~head.req_v | req_cnt_q == '0)));
    assign fire      = ready & retire_yumi_i;
    assign deq_wb    = fire & uses_wb & ~head.trap;
    assign cmt_acc   = commit_v_i & (~cmt_full | fire);
    assign cmt_ovf   = commit_v_i & cmt_full & ~fire;

    always_comb begin
        hc      = '0;
        wb_enq  = '0;
        wb_deq  = '0;
        wb_full = '0;
        for (int c = 0; c < num_rf_p; c++) begin
            if (head.rf_w_v[c]) hc = cw'(c);
            wa[c] = wb_addr_i[c*5 +: 5];
            if (!(c == 0 && wa[c] == 5'd0)) wb_enq[c][wa[c]] = wb_v_i[c];
            for (int a = 0; a < 32; a++)
                wb_full[c][a] = (wb_wr_q[c][a] ^ wb_rd_q[c][a]) == {1'b1, {wp{1'b0}}};
        end
        wb_deq[hc][rd] = deq_wb;
        wb_acc = wb_enq & (~wb_full | wb_deq);
    end

    // Simultaneous request and completion cancel; out-of-range moves hold the count.
    assign inc       = req_v_i & ~req_complete_i;
    assign dec       = req_complete_i & ~req_v_i;
    assign req_ovf   = (inc & req_cnt_q == rw'(req_els_p)) | (dec & req_cnt_q == '0);
    assign req_cnt_d = req_ovf ? req_cnt_q : inc ? req_cnt_q + rw'(1) : dec ? req_cnt_q - rw'(1) : req_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmt_wr_q     <= '0;
            cmt_rd_q     <= '0;
            req_cnt_q    <= '0;
            retire_cnt_q <= '0;
            overflow_q   <= 1'b0;
            for (int c = 0; c < num_rf_p; c++)
                for (int a = 0; a < 32; a++) begin
                    wb_wr_q[c][a] <= '0;
                    wb_rd_q[c][a] <= '0;
                end
        end else begin
            if (cmt_acc) cmt_wr_q <= cmt_wr_q + cptr_t'(1);
            if (fire) cmt_rd_q <= cmt_rd_q + cptr_t'(1);
            if (fire & ~head.trap & ~head.debug) retire_cnt_q <= retire_cnt_q + 32'd1;
            req_cnt_q  <= req_cnt_d;
            overflow_q <= overflow_q | cmt_ovf | req_ovf | |(wb_enq & wb_full & ~wb_deq);
            for (int c = 0; c < num_rf_p; c++)
                for (int a = 0; a < 32; a++) begin
                    if (wb_acc[c][a]) wb_wr_q[c][a] <= wb_wr_q[c][a] + wptr_t'(1);
                    if (wb_deq[c][a]) wb_rd_q[c][a] <= wb_rd_q[c][a] + wptr_t'(1);
                end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmt_acc)
            cmt_mem_q[cmt_wr_q[cp-1:0]] <= '{commit_pc_i, commit_instr_i, commit_trap_i, commit_cause_i,
                                             commit_debug_i, commit_rf_w_v_i, commit_req_v_i};
        for (int c = 0; c < num_rf_p; c++)
            if (wb_acc[c][wa[c]]) wb_mem_q[c][wa[c]][wb_wr_q[c][wa[c]][wp-1:0]] <= wb_data_i[c*64 +: 64];
    end

`ifdef BP_NONSYNTH_COMMIT_WATCHDOG_EN
    localparam int tw = $clog2(timeout_p + 1);
    logic [tw-1:0] stall_q, stall_d;
    logic          hang_q;
    // Backpressure (valid high, yumi low) keeps the counter cleared.
    assign stall_d = (cmt_empty | ready) ? '0 : stall_q == tw'(timeout_p) ? stall_q : stall_q + tw'(1);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
            hang_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            hang_q  <= hang_q | (stall_d == tw'(timeout_p));
        end
    end
    assign hang_o = hang_q;
`else
    assign hang_o = 1'b0;
`endif

    assign retire_v_o      = ready;
    assign retire_pc_o     = {{(64-vaddr_width_p){head.pc[vaddr_width_p-1]}}, head.pc};
    assign retire_instr_o  = head.instr;
    assign retire_trap_o   = head.trap;
    assign retire_cause_o  = head.cause;
    assign retire_debug_o  = head.debug;
    assign retire_rf_sel_o = head.rf_w_v;
    assign retire_wdata_o  = uses_wb ? wb_mem_q[hc][rd][wb_rd_q[hc][rd][wp-1:0]] : 64'd0;
    assign retire_cnt_o    = retire_cnt_q;
    assign overflow_o      = overflow_q;
endmodule
